// File: rtl/mmu.sv
// rtl/mmu.sv - data-side MMU with page-table translation and local word RAM
//
// Purpose:
//   Translates a virtual word address to a physical word address through a
//   NUM_PAGES-entry page table. Each entry holds a valid bit, a frame number
//   and a writable bit. The unit then reads or writes a local
//   2^(FRAME_BITS+PAGE_BITS)-word RAM. Every request finishes in one cycle.
//   Translation misses and writes to read-only pages raise a one-cycle fault.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   virtual_addr      virtual word address
//   data_in           write data
//   mem_read          read request (sampled every edge)
//   mem_write         write request (sampled every edge, wins over read)
//   data_out          registered read data (0 after a faulted read)
//   physical_addr     combinational translation (0 on miss)
//   mem_ready         one-cycle completion pulse
//   fault             one-cycle fault pulse, coincident with mem_ready
//   pt_we             page-table entry write enable
//   pt_index          entry to update
//   pt_frame          new frame number
//   pt_valid          new valid bit
//   pt_writable       new write-permission bit
module mmu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int PAGE_BITS  = 6,
  parameter int NUM_PAGES  = 16,
  parameter int FRAME_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            virtual_addr,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         mem_read,
  input  logic                         mem_write,
  output logic [DATA_W-1:0]            data_out,
  output logic [ADDR_W-1:0]            physical_addr,
  output logic                         mem_ready,
  output logic                         fault,
  input  logic                         pt_we,
  input  logic [$clog2(NUM_PAGES)-1:0] pt_index,
  input  logic [FRAME_BITS-1:0]        pt_frame,
  input  logic                         pt_valid,
  input  logic                         pt_writable
);

  localparam int IDX_W  = $clog2(NUM_PAGES);
  localparam int VPN_W  = ADDR_W - PAGE_BITS;
  localparam int RAM_AW = FRAME_BITS + PAGE_BITS;
  localparam int RAM_D  = 1 << RAM_AW;

  logic [FRAME_BITS-1:0] r_pt_frame [NUM_PAGES];
  logic                  r_pt_valid [NUM_PAGES];
  logic                  r_pt_wr    [NUM_PAGES];
  logic [DATA_W-1:0]     r_ram      [RAM_D];

  logic [VPN_W-1:0]     w_vpn;
  logic [PAGE_BITS-1:0] w_offset;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_miss;
  logic [RAM_AW-1:0]    w_ram_addr;
  logic                 w_req;
  logic                 w_wr_ok;
  logic                 w_fault;

  assign w_vpn    = virtual_addr[ADDR_W-1:PAGE_BITS];
  assign w_offset = virtual_addr[PAGE_BITS-1:0];
  // Low vpn bits select the entry; the range check below catches vpn >= NUM_PAGES.
  assign w_idx    = w_vpn[IDX_W-1:0];
  assign w_miss   = (w_vpn >= VPN_W'(NUM_PAGES)) || !r_pt_valid[w_idx];

  assign w_ram_addr    = {r_pt_frame[w_idx], w_offset};
  assign physical_addr = w_miss ? '0 : {{(ADDR_W-RAM_AW){1'b0}}, w_ram_addr};

  assign w_req   = mem_read | mem_write;
  assign w_wr_ok = mem_write & ~w_miss & r_pt_wr[w_idx];
  // When both requests are high, the write is the access. Its permission decides the fault.
  assign w_fault = w_req & (w_miss | (mem_write & ~r_pt_wr[w_idx]));

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) begin
      r_ram[w_ram_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      mem_ready <= 1'b0;
      fault     <= 1'b0;
      for (int i = 0; i < NUM_PAGES; i++) begin
        r_pt_frame[i] <= FRAME_BITS'(i);
        r_pt_valid[i] <= 1'b1;
        r_pt_wr[i]    <= 1'b1;
      end
    end else begin
      mem_ready <= w_req;
      fault     <= w_fault;
      if (mem_read && !mem_write) begin
        data_out <= w_miss ? '0 : r_ram[w_ram_addr];
      end
      // Translation above used the pre-update entry, so same-cycle accesses see the old mapping.
      if (pt_we) begin
        r_pt_frame[pt_index] <= pt_frame;
        r_pt_valid[pt_index] <= pt_valid;
        r_pt_wr[pt_index]    <= pt_writable;
      end
    end
  end

endmodule

// File: tb/tb_mmu.sv
// tb/tb_mmu.sv - directed self-checking bench for mmu
module tb_mmu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] virtual_addr = '0;
  logic [31:0] data_in = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_out;
  logic [31:0] physical_addr;
  logic        mem_ready;
  logic        fault;
  logic        pt_we = 1'b0;
  logic [3:0]  pt_index = '0;
  logic [3:0]  pt_frame = '0;
  logic        pt_valid = 1'b0;
  logic        pt_writable = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  mmu dut (
    .clk(clk), .rst(rst), .virtual_addr(virtual_addr), .data_in(data_in),
    .mem_read(mem_read), .mem_write(mem_write), .data_out(data_out),
    .physical_addr(physical_addr), .mem_ready(mem_ready), .fault(fault),
    .pt_we(pt_we), .pt_index(pt_index), .pt_frame(pt_frame),
    .pt_valid(pt_valid), .pt_writable(pt_writable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one request at the falling edge, let one rising edge sample it, then drop it.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] din);
    @(negedge clk);
    virtual_addr = addr;
    data_in      = din;
    mem_read     = rd;
    mem_write    = wr;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic pt_write(input logic [3:0] idx, input logic [3:0] frm, input logic v, input logic w);
    @(negedge clk);
    pt_we       = 1'b1;
    pt_index    = idx;
    pt_frame    = frm;
    pt_valid    = v;
    pt_writable = w;
    @(posedge clk);
    #1;
    pt_we = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_data_out", data_out, 0);
    check("rst_ready", {31'b0, mem_ready}, 0);
    check("rst_fault", {31'b0, fault}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Identity map: write 10 <- 42, then read it back
    virtual_addr = 32'd10;
    #1;
    check("pa_10", physical_addr, 10);
    access(1'b0, 1'b1, 32'd10, 32'd42);
    check("wr10_ready", {31'b0, mem_ready}, 1);
    check("wr10_fault", {31'b0, fault}, 0);
    @(posedge clk); #1;
    check("idle_ready", {31'b0, mem_ready}, 0);
    access(1'b1, 1'b0, 32'd10, 32'd0);
    check("rd10_ready", {31'b0, mem_ready}, 1);
    check("rd10_data", data_out, 42);
    check("rd10_fault", {31'b0, fault}, 0);

    // Independent locations
    access(1'b0, 1'b1, 32'd20, 32'd84);
    access(1'b1, 1'b0, 32'd20, 32'd0);
    check("rd20_data", data_out, 84);
    access(1'b1, 1'b0, 32'd10, 32'd0);
    check("rd10b_data", data_out, 42);

    // Remap page 1 to frame 3: vaddr 70 -> 3*64+6 = 198
    pt_write(4'd1, 4'd3, 1'b1, 1'b1);
    @(negedge clk);
    virtual_addr = 32'd70;
    #1;
    check("pa_70", physical_addr, 198);
    access(1'b0, 1'b1, 32'd70, 32'd7);
    check("wr70_fault", {31'b0, fault}, 0);
    access(1'b1, 1'b0, 32'd198, 32'd0);
    check("rd198_data", data_out, 7);

    // Invalidate page 3 in the same cycle as a read of it: the old entry still applies
    @(negedge clk);
    pt_we = 1'b1; pt_index = 4'd3; pt_frame = 4'd3; pt_valid = 1'b0; pt_writable = 1'b1;
    virtual_addr = 32'd198; mem_read = 1'b1;
    @(posedge clk); #1;
    pt_we = 1'b0; mem_read = 1'b0;
    check("samecyc_fault", {31'b0, fault}, 0);
    check("samecyc_data", data_out, 7);
    access(1'b1, 1'b0, 32'd198, 32'd0);
    check("after_inv_fault", {31'b0, fault}, 1);
    check("after_inv_data", data_out, 0);

    // Invalid page 2 and an out-of-range vpn
    pt_write(4'd2, 4'd2, 1'b0, 1'b1);
    access(1'b1, 1'b0, 32'd10, 32'd0);
    check("pre130_data", data_out, 42);
    @(negedge clk);
    virtual_addr = 32'd130;
    #1;
    check("pa_130_miss", physical_addr, 0);
    access(1'b1, 1'b0, 32'd130, 32'd0);
    check("rd130_fault", {31'b0, fault}, 1);
    check("rd130_ready", {31'b0, mem_ready}, 1);
    check("rd130_data", data_out, 0);
    @(posedge clk); #1;
    check("rd130_fault_clear", {31'b0, fault}, 0);
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    check("rd1024_fault", {31'b0, fault}, 1);

    // Read-only page 0
    pt_write(4'd0, 4'd0, 1'b1, 1'b0);
    access(1'b0, 1'b1, 32'd10, 32'd99);
    check("wr_ro_fault", {31'b0, fault}, 1);
    check("wr_ro_ready", {31'b0, mem_ready}, 1);
    access(1'b1, 1'b0, 32'd10, 32'd0);
    check("rd_ro_data", data_out, 42);
    check("rd_ro_fault", {31'b0, fault}, 0);
    pt_write(4'd0, 4'd0, 1'b1, 1'b1);

    // Read and write together: write wins, data_out unchanged, single pulse
    access(1'b1, 1'b1, 32'd5, 32'd55);
    check("both_ready", {31'b0, mem_ready}, 1);
    check("both_data", data_out, 42);
    check("both_fault", {31'b0, fault}, 0);
    @(posedge clk); #1;
    check("both_single_pulse", {31'b0, mem_ready}, 0);
    access(1'b1, 1'b0, 32'd5, 32'd0);
    check("rd5_data", data_out, 55);

    // Held read: serviced every cycle
    @(negedge clk);
    virtual_addr = 32'd20; mem_read = 1'b1;
    @(posedge clk); #1;
    check("held_ready1", {31'b0, mem_ready}, 1);
    check("held_data1", data_out, 84);
    virtual_addr = 32'd10;
    @(posedge clk); #1;
    mem_read = 1'b0;
    check("held_ready2", {31'b0, mem_ready}, 1);
    check("held_data2", data_out, 42);

    // Reset mid-request cancels the pulse and restores the identity map
    access(1'b1, 1'b0, 32'd5, 32'd0);
    check("pre_rst_ready", {31'b0, mem_ready}, 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'b0, mem_ready}, 0);
    check("midrst_data", data_out, 0);
    check("midrst_fault", {31'b0, fault}, 0);
    virtual_addr = 32'd130;
    #1;
    check("rst_identity_130", physical_addr, 130);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mmu.md
Name: mmu

Overview:
- Data-side memory management unit with a small page-table translator and a local word-addressed data RAM.
- Converts a 32-bit virtual word address to a physical word address through a programmable page table, then performs the read or write on the internal RAM.
- Sits between the CPU load/store stage and data storage, and reports translation and permission faults.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, virtual and physical address width.
- PAGE_BITS, 6, in-page offset width (64-word pages).
- NUM_PAGES, 16, number of virtual pages and page-table entries.
- FRAME_BITS, 4, physical frame index width. RAM depth is 2^(FRAME_BITS+PAGE_BITS) = 1024 words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- virtual_addr  in  ADDR_W  virtual word address (word-addressed, not byte).
- data_in  in  DATA_W  write data.
- mem_read  in  1  read request; sampled each rising edge.
- mem_write  in  1  write request; sampled each rising edge.
- data_out  out  DATA_W  registered read data.
- physical_addr  out  ADDR_W  combinational translation of virtual_addr.
- mem_ready  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle fault pulse, coincident with mem_ready.
- pt_we  in  1  page-table entry write enable.
- pt_index  in  log2(NUM_PAGES)  entry to write.
- pt_frame  in  FRAME_BITS  new frame number.
- pt_valid  in  1  new valid bit.
- pt_writable  in  1  new write-permission bit.

Behaviour:
- Address split: vpn = virtual_addr[ADDR_W-1:PAGE_BITS], offset = virtual_addr[PAGE_BITS-1:0].
- physical_addr is combinational: {frame of entry vpn, offset}, zero-extended to ADDR_W. It is 0 when vpn >= NUM_PAGES or the entry is invalid.
- Translation miss: vpn >= NUM_PAGES or entry valid = 0.
- Reset (asynchronous):
  - data_out = 0, mem_ready = 0, fault = 0.
  - Page-table entry i = {valid=1, frame=i, writable=1}, giving an identity map for addresses 0..1023.
  - RAM contents are not cleared.
- Write: mem_write high at a rising edge with no miss and writable = 1 stores data_in at physical_addr on that edge. mem_ready pulses high the following cycle. data_out is unchanged.
- Read: mem_read high at a rising edge with no miss loads data_out with RAM[physical_addr] on that edge. mem_ready pulses the following cycle. One-cycle latency.
- Both mem_read and mem_write high: the write is performed and the read is ignored. data_out is unchanged and a single mem_ready pulse is produced.
- Fault cases: translation miss on any request, or write to a writable = 0 entry.
  - No RAM update.
  - On a faulted read, data_out is loaded with 0.
  - mem_ready and fault both pulse for one cycle.
- Requests held high for N cycles are serviced every cycle (N accesses, N ready pulses). There is no backpressure.
- Page table:
  - pt_we at a rising edge updates entry pt_index.
  - An access in the same cycle uses the old entry; the new entry applies from the next edge.
  - A simultaneous pt_we and access to the same page is legal.
- rst asserted mid-access: the pending mem_ready/fault pulse is cancelled, outputs return to reset values, and the page table returns to identity.
- Idle (no request): mem_ready = 0, fault = 0, data_out holds its last value.

Test Plan:
- Reset, write vaddr 10 data 42, then read vaddr 10 -> physical_addr = 10, mem_ready pulses after each access, data_out = 42, fault = 0.
- Write vaddr 20 data 84, read 20, then read 10 -> data_out = 84, then 42. Locations are independent.
- pt_we index 1 -> frame 3, writable. Write vaddr 70 (page 1, offset 6) data 7 -> physical_addr = 198. Read vaddr 198 -> 7.
- pt_we index 2 with valid = 0. Read vaddr 130 -> fault = 1 and mem_ready = 1 for one cycle, data_out = 0. Read vaddr 1024 (vpn 16) -> fault.
- Set entry 0 writable = 0. Write vaddr 10 data 99 -> fault pulses. Read vaddr 10 -> still 42.
- mem_read and mem_write together at vaddr 5 with data 55 -> one ready pulse, data_out unchanged. Next read of 5 -> 55. Assert rst mid-request -> mem_ready = 0 and data_out = 0 immediately.
